// File: rtl/ex_stage_mc_pkg.sv
// Shared types for the multi-cycle execute stage: ALU/MDU op encodings and FSM states.
package ex_stage_mc_pkg;

  typedef enum logic [2:0] {
    MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_MULHU,
    MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU
  } mdu_op_e;

  typedef enum logic [1:0] {EX_IDLE, EX_DIV, EX_DIV_FIN} ex_state_e;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
  } alu_op_e;

  function automatic int div_cycles(int word_w, int bits_per_cycle);
    return word_w / bits_per_cycle;
  endfunction

endpackage

// File: rtl/ex_stage_mc_alu.sv
// Combinational integer ALU; its result also drives the branch zero test.
module alu
  import ex_stage_mc_pkg::*;
#(
  parameter int W    = 32,
  parameter int OP_W = 4
) (
  input  logic [OP_W-1:0] op_i,
  input  logic [W-1:0]    a_i,
  input  logic [W-1:0]    b_i,
  output logic [W-1:0]    res_o
);
  localparam int SW = $clog2(W);

  logic [SW-1:0] shamt;
  assign shamt = b_i[SW-1:0];

  always_comb begin
    res_o = a_i + b_i;
    case (alu_op_e'(4'(op_i)))
      ALU_ADD:  res_o = a_i + b_i;
      ALU_SUB:  res_o = a_i - b_i;
      ALU_XOR:  res_o = a_i ^ b_i;
      ALU_OR:   res_o = a_i | b_i;
      ALU_AND:  res_o = a_i & b_i;
      ALU_SLL:  res_o = a_i << shamt;
      ALU_SRL:  res_o = a_i >> shamt;
      ALU_SRA:  res_o = W'($signed(a_i) >>> shamt);
      ALU_SLT:  res_o = W'($signed(a_i) < $signed(b_i));
      ALU_SLTU: res_o = W'(a_i < b_i);
      default:  ;
    endcase
  end

endmodule

// File: rtl/ex_stage_mc_div_iter.sv
// Iterative restoring divider on magnitudes, R quotient bits per cycle,
// with sign and divide-by-zero / overflow correction applied on the held result.
module div_iter #(
  parameter int W = 32,
  parameter int R = 1,
  parameter int N = W / R
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         kill_i,
  input  logic         start_i,
  input  logic [W-1:0] op_a_i,
  input  logic [W-1:0] op_b_i,
  input  logic         signed_i,
  input  logic         rem_i,
  output logic         done_o,
  output logic [W-1:0] result_o
);
  localparam int CW = $clog2(N + 1);

  logic [CW-1:0] cnt;
  logic [W-1:0]  prem, quo, dvs, a_q;
  logic          neg_q, neg_r, div0, ovf, rem_sel;
  logic [W-1:0]  prem_nx, quo_nx, q_fix, r_fix;
  logic [W:0]    trial;

  always_comb begin
    prem_nx = prem;
    quo_nx  = quo;
    trial   = '0;
    for (int k = 0; k < R; k++) begin
      trial  = {prem_nx, quo_nx[W-1]};
      quo_nx = {quo_nx[W-2:0], 1'b0};
      if (trial >= {1'b0, dvs}) begin
        trial     = trial - {1'b0, dvs};
        quo_nx[0] = 1'b1;
      end
      prem_nx = trial[W-1:0];
    end
  end

  assign q_fix  = neg_q ? -quo : quo;
  assign r_fix  = neg_r ? -prem : prem;
  assign done_o = (cnt == CW'(1));

  // Special cases override the magnitude path so latency never depends on operands.
  always_comb begin
    if (div0)     result_o = rem_sel ? a_q : '1;
    else if (ovf) result_o = rem_sel ? '0 : a_q;
    else          result_o = rem_sel ? r_fix : q_fix;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= '0; prem <= '0; quo <= '0; dvs <= '0; a_q <= '0;
      neg_q <= 1'b0; neg_r <= 1'b0; div0 <= 1'b0; ovf <= 1'b0; rem_sel <= 1'b0;
    end else if (kill_i) begin
      cnt <= '0;
    end else if (start_i) begin
      cnt     <= CW'(N);
      prem    <= '0;
      quo     <= (signed_i && op_a_i[W-1]) ? -op_a_i : op_a_i;
      dvs     <= (signed_i && op_b_i[W-1]) ? -op_b_i : op_b_i;
      a_q     <= op_a_i;
      neg_q   <= signed_i && (op_a_i[W-1] ^ op_b_i[W-1]);
      neg_r   <= signed_i && op_a_i[W-1];
      div0    <= (op_b_i == '0);
      ovf     <= signed_i && (op_a_i == {1'b1, {(W-1){1'b0}}}) && (op_b_i == '1);
      rem_sel <= rem_i;
    end else if (cnt != '0) begin
      prem <= prem_nx;
      quo  <= quo_nx;
      cnt  <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/ex_stage_mc.sv
// Handshaked execute stage: registered result slot, single-cycle ALU/MUL/branch,
// iterative DIV/REM with constant latency, and pipeline flush.
module ex_stage_mc
  import ex_stage_mc_pkg::*;
#(
  parameter int WORD_WIDTH         = 32,
  parameter int ADDR_WIDTH         = 5,
  parameter int ALU_OP_WIDTH       = 4,
  parameter int RISCV_M_CORE       = 1,
  parameter int DIV_BITS_PER_CYCLE = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  logic                    id_valid_i,
  output logic                    ex_ready_o,
  input  logic [WORD_WIDTH-1:0]   operand_a_i,
  input  logic [WORD_WIDTH-1:0]   operand_b_i,
  input  logic [ALU_OP_WIDTH-1:0] alu_op_i,
  input  logic                    mdu_en_i,
  input  logic                    branch_en_i,
  input  logic                    zeroflag_inv_i,
  input  logic [WORD_WIDTH-1:0]   pc_i,
  input  logic [WORD_WIDTH-1:0]   branch_imm_i,
  input  logic [ADDR_WIDTH-1:0]   rd_addr_i,
  input  logic                    rd_we_i,
  output logic                    wb_valid_o,
  input  logic                    wb_ready_i,
  output logic [WORD_WIDTH-1:0]   wb_data_o,
  output logic [ADDR_WIDTH-1:0]   wb_addr_o,
  output logic                    wb_we_o,
  output logic                    branch_taken_o,
  output logic [WORD_WIDTH-1:0]   branch_addr_o,
  output logic                    busy_o
);
  localparam int W          = WORD_WIDTH;
  localparam int DIV_CYCLES = div_cycles(W, DIV_BITS_PER_CYCLE);

  ex_state_e             state;
  mdu_op_e               mdu_op;
  logic                  mdu_en, is_div, accept, div_done, br_taken, we_eff;
  logic [W-1:0]          alu_res, mul_res, div_res, op_res;
  logic signed [W:0]     mul_a, mul_b;
  logic signed [2*W-1:0] prod;
  logic [ADDR_WIDTH-1:0] div_rd_addr;
  logic                  div_rd_we;

  assign mdu_en     = (RISCV_M_CORE != 0) && mdu_en_i;
  assign mdu_op     = mdu_op_e'(alu_op_i[2:0]);
  assign is_div     = mdu_en && alu_op_i[2];
  assign ex_ready_o = (state == EX_IDLE) && (!wb_valid_o || wb_ready_i) && !flush_i;
  assign accept     = id_valid_i && ex_ready_o;
  assign busy_o     = (state == EX_DIV);
  assign we_eff     = rd_we_i && (rd_addr_i != '0) && !branch_en_i;

  alu #(.W(W), .OP_W(ALU_OP_WIDTH)) u_alu (
    .op_i (alu_op_i),
    .a_i  (operand_a_i),
    .b_i  (operand_b_i),
    .res_o(alu_res)
  );

  // One extra sign bit per operand covers all of MULH/MULHSU/MULHU with one signed multiply.
  assign mul_a   = {(mdu_op == MDU_MULH || mdu_op == MDU_MULHSU) && operand_a_i[W-1], operand_a_i};
  assign mul_b   = {(mdu_op == MDU_MULH) && operand_b_i[W-1], operand_b_i};
  assign prod    = mul_a * mul_b;
  assign mul_res = (mdu_op == MDU_MUL) ? prod[W-1:0] : prod[2*W-1:W];
  assign op_res  = mdu_en ? mul_res : alu_res;

  assign br_taken = (alu_res == '0) ^ zeroflag_inv_i;

  div_iter #(.W(W), .R(DIV_BITS_PER_CYCLE), .N(DIV_CYCLES)) u_div (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .kill_i  (flush_i),
    .start_i (accept && is_div),
    .op_a_i  (operand_a_i),
    .op_b_i  (operand_b_i),
    .signed_i(!alu_op_i[0]),
    .rem_i   (alu_op_i[1]),
    .done_o  (div_done),
    .result_o(div_res)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= EX_IDLE;
      wb_valid_o     <= 1'b0;
      wb_data_o      <= '0;
      wb_addr_o      <= '0;
      wb_we_o        <= 1'b0;
      branch_taken_o <= 1'b0;
      branch_addr_o  <= '0;
      div_rd_addr    <= '0;
      div_rd_we      <= 1'b0;
    end else begin
      branch_taken_o <= 1'b0;
      if (flush_i) begin
        state      <= EX_IDLE;
        wb_valid_o <= 1'b0;
      end else begin
        if (wb_valid_o && wb_ready_i) wb_valid_o <= 1'b0;
        case (state)
          EX_IDLE: if (accept) begin
            if (is_div) begin
              state       <= EX_DIV;
              div_rd_addr <= rd_addr_i;
              div_rd_we   <= we_eff;
            end else begin
              wb_valid_o <= 1'b1;
              wb_data_o  <= op_res;
              wb_addr_o  <= rd_addr_i;
              wb_we_o    <= we_eff;
              if (branch_en_i) begin
                branch_taken_o <= br_taken;
                branch_addr_o  <= pc_i + branch_imm_i;
              end
            end
          end
          EX_DIV: if (div_done) state <= EX_DIV_FIN;
          EX_DIV_FIN: if (!wb_valid_o || wb_ready_i) begin
            state      <= EX_IDLE;
            wb_valid_o <= 1'b1;
            wb_data_o  <= div_res;
            wb_addr_o  <= div_rd_addr;
            wb_we_o    <= div_rd_we;
          end
          default: state <= EX_IDLE;
        endcase
      end
    end
  end

endmodule
